// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver with independent full-duplex paths on one clock.
// Define UART_FRAMING_ERR_EN to add o_RX_Frame_Err (stop bit sampled low).
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
`ifdef UART_FRAMING_ERR_EN
    output logic       o_RX_Frame_Err,
`endif
    output logic [7:0] o_RX_Byte
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_CLEANUP
    } state_t;

    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_serial_q, tx_serial_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q, tx_done_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_byte_d   = tx_byte_q;
        tx_active_d = tx_active_q;
        tx_done_d   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_idx_d = '0;
                if (i_TX_DV) begin
                    tx_byte_d   = i_TX_Byte;
                    tx_active_d = 1'b1;
                    tx_state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_done_d   = 1'b1;
                    tx_active_d = 1'b0;
                    tx_state_d  = ST_CLEANUP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so it tracks the FSM exactly.
        case (tx_state_d)
            ST_START: tx_serial_d = 1'b0;
            ST_DATA:  tx_serial_d = tx_byte_d[tx_idx_d];
            default:  tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        tx_byte_q <= tx_byte_d;
    end

    assign o_TX_Serial = tx_serial_q;
    assign o_TX_Active = tx_active_q;
    assign o_TX_Done   = tx_done_q;

    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q, rx_dv_d;
    logic             rx_meta_q, rx_sync_q;
`ifdef UART_FRAMING_ERR_EN
    logic             rx_ferr_q, rx_ferr_d;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
`ifdef UART_FRAMING_ERR_EN
        rx_ferr_d  = 1'b0;
`endif
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Recheck at mid start bit; a line already back high was a glitch.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_idx_q] = rx_sync_q;
                    rx_idx_d             = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_CLEANUP;
`ifdef UART_FRAMING_ERR_EN
                    if (rx_sync_q) begin
                        rx_dv_d   = 1'b1;
                        rx_byte_d = rx_shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
`else
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_shift_q;
`endif
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
`ifdef UART_FRAMING_ERR_EN
            rx_ferr_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= i_RX_Serial;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
`ifdef UART_FRAMING_ERR_EN
            rx_ferr_q  <= rx_ferr_d;
`endif
        end
    end

    always_ff @(posedge i_Clock) begin
        rx_shift_q <= rx_shift_d;
    end

    assign o_RX_DV   = rx_dv_q;
    assign o_RX_Byte = rx_byte_q;
`ifdef UART_FRAMING_ERR_EN
    assign o_RX_Frame_Err = rx_ferr_q;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Loopback bench for uart_transceiver: TX drives RX, received bytes checked against a queue.
module tb_uart_transceiver;
    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_active, tx_serial, tx_done;
    logic       rx_line;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       force_low = 1'b0;
`ifdef UART_FRAMING_ERR_EN
    logic       rx_ferr;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    assign rx_line = force_low ? 1'b0 : (tx_active ? tx_serial : 1'b1);

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_TX_DV        (tx_dv),
        .i_TX_Byte      (tx_byte),
        .o_TX_Active    (tx_active),
        .o_TX_Serial    (tx_serial),
        .o_TX_Done      (tx_done),
        .i_RX_Serial    (rx_line),
        .o_RX_DV        (rx_dv),
`ifdef UART_FRAMING_ERR_EN
        .o_RX_Frame_Err (rx_ferr),
`endif
        .o_RX_Byte      (rx_byte)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: counts pulses and scores each received byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_done) done_cnt++;
`ifdef UART_FRAMING_ERR_EN
            if (rx_ferr) ferr_cnt++;
`endif
            if (rx_dv) begin
                rx_cnt++;
                if (sb.size() == 0) begin
                    check_val("rx_extra", sb.size(), 1);
                end else begin
                    check_val("rx_byte", rx_byte, sb.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit expect_rx);
        @(negedge clk);
        tx_dv   = 1'b1;
        tx_byte = b;
        if (expect_rx) sb.push_back(b);
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) check_val("done_timeout", done_cnt, start + 1);
        @(negedge clk);
    endtask

    task automatic wait_rx();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("rx_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int cyc;
        int d0;
        int r0;
        logic [7:0] pat [4];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'hAA;

        repeat (4) @(negedge clk);
        check_val("rst_serial", tx_serial, 1);
        check_val("rst_active", tx_active, 0);
        check_val("rst_done", tx_done, 0);
        check_val("rst_rx_dv", rx_dv, 0);
        check_val("rst_rx_byte", rx_byte, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte, frame length measured from the strobe to Active dropping.
        d0 = done_cnt;
        send_byte(8'h3F, 1'b1);
        cyc = 1;
        while (tx_active && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("active_len", cyc, 10 * CPB + 1);
        check_val("done_at_end", tx_done, 1);
        wait_rx();
        repeat (5) @(negedge clk);
        check_val("done_cnt_single", done_cnt - d0, 1);
        check_val("rx_hold_3f", rx_byte, 8'h3F);

        // Back-to-back frames, each started once the previous one reports done.
        d0 = done_cnt;
        r0 = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            send_byte(pat[i], 1'b1);
            wait_done();
        end
        wait_rx();
        check_val("b2b_rx_cnt", rx_cnt - r0, 4);
        check_val("b2b_done_cnt", done_cnt - d0, 4);

        // A strobe while busy must be ignored.
        d0 = done_cnt;
        r0 = rx_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (500) @(negedge clk);
        send_byte(8'h12, 1'b0);
        wait_done();
        wait_rx();
        repeat (2500) @(negedge clk);
        check_val("busy_done_cnt", done_cnt - d0, 1);
        check_val("busy_rx_cnt", rx_cnt - r0, 1);

        // Short low glitch is rejected, and the receiver still works afterwards.
        r0 = rx_cnt;
        force_low = 1'b1;
        repeat (50) @(negedge clk);
        force_low = 1'b0;
        repeat (2500) @(negedge clk);
        check_val("glitch_rx_cnt", rx_cnt - r0, 0);
        send_byte(8'h96, 1'b1);
        wait_done();
        wait_rx();
        check_val("after_glitch", rx_byte, 8'h96);

        // Reset mid-frame, with a strobe on the same cycle.
        send_byte(8'hC3, 1'b0);
        repeat (1000) @(negedge clk);
        rst     = 1'b1;
        tx_dv   = 1'b1;
        tx_byte = 8'hE7;
        @(posedge clk);
        #1;
        check_val("rst_mid_serial", tx_serial, 1);
        check_val("rst_mid_active", tx_active, 0);
        check_val("rst_mid_rx_byte", rx_byte, 0);
        @(negedge clk);
        rst   = 1'b0;
        tx_dv = 1'b0;
        @(negedge clk);
        check_val("rst_beats_dv", tx_active, 0);
        send_byte(8'h3C, 1'b1);
        wait_done();
        wait_rx();
        check_val("after_rst", rx_byte, 8'h3C);

`ifdef UART_FRAMING_ERR_EN
        // Stop bit held low: error pulse instead of a byte.
        r0 = rx_cnt;
        d0 = ferr_cnt;
        send_byte(8'h5A, 1'b0);
        repeat (9 * CPB) @(negedge clk);
        force_low = 1'b1;
        repeat (CPB) @(negedge clk);
        force_low = 1'b0;
        repeat (600) @(negedge clk);
        check_val("ferr_cnt", ferr_cnt - d0, 1);
        check_val("ferr_no_dv", rx_cnt - r0, 0);
        check_val("ferr_byte_kept", rx_byte, 8'h3C);
`endif

        repeat (20) @(negedge clk);
        check_val("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
